// File: rtl/sw_debounce_irq.sv
// Per-switch debouncer with sticky edge-pending flags and a level interrupt.
// Each switch bit lives in its own lane; the top only merges pending into irq.

module sw_debounce_lane #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_raw,
   input  logic irq_en,
   input  logic edge_mode,
   input  logic clr,
   output logic sw_db,
   output logic pending
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          db_nxt, evt, pend_nxt;

   always_comb begin
      db_nxt  = sw_db;
      cnt_nxt = '0;
      if (sync[1] != sw_db) begin
         if (cnt == CNT_LAST) db_nxt = sync[1];
         else                 cnt_nxt = cnt + CW'(1);
      end
      // falling edges count only in both-edge mode
      evt      = (db_nxt & ~sw_db) | (edge_mode & sw_db & ~db_nxt);
      pend_nxt = (evt & irq_en) | (pending & ~clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync    <= '0;
         cnt     <= '0;
         sw_db   <= 1'b0;
         pending <= 1'b0;
      end else begin
         sync    <= {sync[0], sw_raw};
         cnt     <= cnt_nxt;
         sw_db   <= db_nxt;
         pending <= pend_nxt;
      end
   end
endmodule

module sw_debounce_irq #(
   parameter int DATA_WIDTH      = 4,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] sw_in,
   input  logic [DATA_WIDTH-1:0] irq_en,
   input  logic [DATA_WIDTH-1:0] edge_mode,
   input  logic [DATA_WIDTH-1:0] irq_clr,
   input  logic                  irq_clr_we,
   output logic [DATA_WIDTH-1:0] sw_db,
   output logic [DATA_WIDTH-1:0] pending,
   output logic                  irq
);
   logic [DATA_WIDTH-1:0] clr;

   assign clr = irq_clr_we ? irq_clr : '0;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
      sw_debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .sw_raw    (sw_in[i]),
         .irq_en    (irq_en[i]),
         .edge_mode (edge_mode[i]),
         .clr       (clr[i]),
         .sw_db     (sw_db[i]),
         .pending   (pending[i])
      );
   end

   // irq lags pending by one cycle; masking by irq_en leaves pending intact
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) irq <= 1'b0;
      else      irq <= |(pending & irq_en);
   end
endmodule

// File: tb/tb_sw_debounce_irq.sv
// Directed bench for sw_debounce_irq: sliding-window reference model checked
// every cycle, plus literal expectations at the edges that matter.

module tb_sw_debounce_irq;
   localparam int DW = 4;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] sw_in, irq_en, edge_mode, irq_clr;
   logic          irq_clr_we;
   logic [DW-1:0] sw_db, pending;
   logic          irq;

   int vectors = 0;
   int errors  = 0;
   bit chk_on  = 1'b0;

   sw_debounce_irq #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DC)) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_in      (sw_in),
      .irq_en     (irq_en),
      .edge_mode  (edge_mode),
      .irq_clr    (irq_clr),
      .irq_clr_we (irq_clr_we),
      .sw_db      (sw_db),
      .pending    (pending),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Reference: hist[k] is sw_in as seen k+1 edges ago. The synchronizer shows
   // the sample from two edges back, so a level is accepted once the DC
   // synchronized samples hist[1..DC] all disagree with the debounced value.
   logic [DW-1:0] hist [0:DC];
   logic [DW-1:0] m_db, m_pend, m_new, m_ev, m_clr, all_diff;
   logic          m_irq;

   always_comb begin
      all_diff = '1;
      for (int k = 1; k <= DC; k++) all_diff = all_diff & (hist[k] ^ m_db);
      m_new = m_db ^ all_diff;
      m_ev  = (m_new & ~m_db) | (edge_mode & m_db & ~m_new);
      m_clr = irq_clr_we ? irq_clr : '0;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k <= DC; k++) hist[k] <= '0;
         m_db   <= '0;
         m_pend <= '0;
         m_irq  <= 1'b0;
      end else begin
         for (int k = DC; k > 0; k--) hist[k] <= hist[k-1];
         hist[0] <= sw_in;
         m_db    <= m_new;
         m_pend  <= (m_pend & ~m_clr) | (m_ev & irq_en);
         m_irq   <= |(m_pend & irq_en);
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_sw_db", sw_db, m_db);
         chk("model_pending", pending, m_pend);
         chk("model_irq", {3'b000, irq}, {3'b000, m_irq});
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear(input logic [DW-1:0] mask);
      irq_clr    = mask;
      irq_clr_we = 1'b1;
      step(1);
      irq_clr_we = 1'b0;
      irq_clr    = '0;
   endtask

   initial begin
      rst = 1'b1; sw_in = '0; irq_en = '0; edge_mode = '0; irq_clr = '0; irq_clr_we = 1'b0;
      #1 rst = 1'b0;
      #1 chk_on = 1'b1;
      step(2);
      chk("reset_sw_db", sw_db, 4'b0000);
      chk("reset_pending", pending, 4'b0000);
      chk("reset_irq", {3'b000, irq}, 4'b0000);
      #2 rst = 1'b1;

      // first debounced rise lands on edge 6, irq on edge 7
      step(1);
      irq_en = 4'hF; sw_in = 4'b0001;
      step(5);
      chk("rise_edge5_sw_db", sw_db, 4'b0000);
      step(1);
      chk("rise_edge6_sw_db", sw_db, 4'b0001);
      chk("rise_edge6_pending", pending, 4'b0001);
      chk("rise_edge6_irq", {3'b000, irq}, 4'b0000);
      step(1);
      chk("rise_edge7_irq", {3'b000, irq}, 4'b0001);

      // 3-cycle glitch on bit 1 must vanish
      sw_in = 4'b0011; step(3);
      sw_in = 4'b0001; step(10);
      chk("glitch_sw_db", sw_db, 4'b0001);
      chk("glitch_pending", pending, 4'b0001);

      // bit 2 chatters for 40 cycles then settles high
      for (int t = 0; t < 20; t++) begin
         sw_in[2] = ~sw_in[2];
         step(2);
         chk("chatter_sw_db", sw_db, 4'b0001);
      end
      sw_in[2] = 1'b1;
      step(5);
      chk("chatter_edge5_sw_db", sw_db, 4'b0001);
      step(1);
      chk("chatter_edge6_sw_db", sw_db, 4'b0101);
      chk("chatter_pending", pending, 4'b0101);
      step(1);

      // clears: irq stays while bit 2 pending, drops a cycle after last clear
      clear(4'b0001);
      chk("clr0_pending", pending, 4'b0100);
      chk("clr0_irq", {3'b000, irq}, 4'b0001);
      clear(4'b0100);
      chk("clr2_pending", pending, 4'b0000);
      chk("clr2_irq_lag", {3'b000, irq}, 4'b0001);
      step(1);
      chk("clr2_irq", {3'b000, irq}, 4'b0000);

      // both-edge mode on bit 3
      edge_mode = 4'b1000;
      sw_in = 4'b1101; step(6);
      chk("b3_rise_pending", pending, 4'b1000);
      clear(4'b1000);
      chk("b3_clr_pending", pending, 4'b0000);
      sw_in = 4'b0101; step(6);
      chk("b3_fall_sw_db", sw_db, 4'b0101);
      chk("b3_fall_pending", pending, 4'b1000);
      clear(4'b1000);
      sw_in = 4'b1101; step(5);
      clear(4'b1000);
      chk("set_wins_pending", pending, 4'b1000);
      chk("set_wins_sw_db", sw_db, 4'b1101);
      clear(4'b1000);

      // disabled bit: event discarded
      irq_en = 4'b0111;
      sw_in = 4'b0101; step(8);
      chk("masked_sw_db", sw_db, 4'b0101);
      chk("masked_pending", pending, 4'b0000);

      // masking irq_en hides irq but keeps pending
      irq_en = 4'hF; edge_mode = 4'b0000;
      sw_in = 4'b0100; step(8);
      sw_in = 4'b1100; step(8);
      chk("mask_pending_set", pending, 4'b1000);
      irq_en = 4'b0111; step(2);
      chk("mask_irq", {3'b000, irq}, 4'b0000);
      chk("mask_pending_kept", pending, 4'b1000);
      irq_en = 4'hF;
      clear(4'b1000);

      // reset mid-count on bit 0 (cnt reaches 2 after four edges)
      sw_in = 4'b1101; step(4);
      #2 rst = 1'b0;
      #1;
      chk("midrst_sw_db", sw_db, 4'b0000);
      chk("midrst_pending", pending, 4'b0000);
      chk("midrst_irq", {3'b000, irq}, 4'b0000);
      step(1);
      #2 rst = 1'b1;
      step(5);
      chk("postrst_edge5_sw_db", sw_db, 4'b0000);
      step(1);
      chk("postrst_edge6_sw_db", sw_db, 4'b1101);
      chk("postrst_pending", pending, 4'b1101);
      step(2);
      chk("postrst_irq", {3'b000, irq}, 4'b0001);

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/sw_debounce_irq.md
SW_DEBOUNCE_IRQ -- requirements
Module: sw_debounce_irq

Interface
REQ-001 Parameter DATA_WIDTH, default 4, number of switch inputs handled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles needed to accept a new level; legal range >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled by the SoC reset generator.
REQ-005 sw_in  input  DATA_WIDTH  raw, asynchronous switch/button levels from pads.
REQ-006 irq_en  input  DATA_WIDTH  per-bit interrupt enable.
REQ-007 edge_mode  input  DATA_WIDTH  per-bit: 0 = capture rising debounced edges only, 1 = capture both edges.
REQ-008 irq_clr  input  DATA_WIDTH  per-bit clear mask, sampled only when irq_clr_we = 1.
REQ-009 irq_clr_we  input  1  one-cycle write strobe for irq_clr.
REQ-010 sw_db  output  DATA_WIDTH  registered debounced levels; drives the sw input of the GPIO register stage.
REQ-011 pending  output  DATA_WIDTH  registered sticky edge-pending flags.
REQ-012 irq  output  1  registered interrupt request, level.

Function
REQ-013 Each sw_in bit SHALL pass a 2-flop synchronizer; sw_sync = second stage.
REQ-014 Each bit SHALL own a counter of width clog2(DEBOUNCE_CYCLES), bits independent.
REQ-015 If sw_sync[i] == sw_db[i], cnt[i] SHALL load 0.
REQ-016 If sw_sync[i] != sw_db[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-017 If sw_sync[i] != sw_db[i] and cnt[i] == DEBOUNCE_CYCLES-1, sw_db[i] SHALL load sw_sync[i] and cnt[i] SHALL load 0; counter never wraps.
REQ-018 Latency: a clean sw_in change SHALL appear on sw_db after exactly DEBOUNCE_CYCLES+2 rising edges, counting the first edge sampling the new level as edge 1.
REQ-019 Any single cycle with sw_sync[i] == sw_db[i] SHALL restart the count; pulses shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach sw_db.
REQ-020 Debounced event on bit i = sw_db[i] 0->1, or sw_db[i] 1->0 when edge_mode[i] = 1; detected in the cycle sw_db[i] updates (compare next vs current value).
REQ-021 pending[i] SHALL set on the edge that updates sw_db[i] when an event occurs and irq_en[i] = 1; events with irq_en[i] = 0 SHALL be discarded.
REQ-022 pending[i] SHALL clear on a clock edge where irq_clr_we = 1 and irq_clr[i] = 1; otherwise it holds.
REQ-023 Simultaneous set and clear on the same bit SHALL leave pending[i] = 1 (set wins).
REQ-024 irq SHALL register |(pending & irq_en) each cycle, lagging pending by one cycle; deasserting irq_en[i] masks but does not clear pending[i].
REQ-025 irq_clr, irq_en, edge_mode changes SHALL take effect on the next rising edge; no handshake or back-pressure exists.

Reset
REQ-026 While rst = 0: sync flops, cnt, sw_db, pending and irq SHALL be 0, asynchronously.
REQ-027 After rst release with sw_in[i] held 1, sw_db[i] SHALL rise after DEBOUNCE_CYCLES+2 edges and set pending[i] if irq_en[i] = 1 (intended power-on event).
REQ-028 Reset asserted mid-count SHALL discard partial counts; counting restarts from 0 after release.

Verification (DEBOUNCE_CYCLES = 4, DATA_WIDTH = 4)
REQ-029 sw_in = 4'b0001 held, irq_en = 4'hF, edge_mode = 0 -> sw_db = 4'b0001 on edge 6, pending = 4'b0001 same edge, irq = 1 on edge 7.
REQ-030 sw_in[1] pulses high 3 cycles then low -> sw_db, pending, irq stay 0.
REQ-031 sw_in[2] toggles every 2 cycles for 40 cycles, then holds 1 -> sw_db[2] changes exactly once, 6 edges after the final toggle.
REQ-032 pending = 4'b0101, irq_clr = 4'b0001, irq_clr_we pulse -> pending = 4'b0100, irq stays 1; second clear of bit 2 -> pending = 0, irq = 0 one cycle later.
REQ-033 edge_mode[3] = 1, sw_in[3] 1->0 after debounced high, cleared pending -> pending[3] sets again; same event with irq_clr_we clearing bit 3 in that cycle -> pending[3] = 1.
REQ-034 rst pulsed low with cnt[0] = 2 mid-transition -> all outputs 0 immediately; after release sw_db[0] needs the full 6 edges.
